// File: rtl/pad_io_pkg.sv
// Shared constants, types and helpers for the pad I/O conditioning slice.
package pad_io_pkg;

  localparam int unsigned AttrDw   = 6;
  localparam int unsigned FiltCntW = 16;

  typedef logic [AttrDw-1:0]   pad_attr_t;
  typedef logic [FiltCntW-1:0] filt_cnt_t;

  // Open-drain emulation: only ever drive low, release the pad for a 1.
  function automatic logic pad_oe(logic oe_req, logic out_req, logic od_en);
    return od_en ? (oe_req & ~out_req) : oe_req;
  endfunction

  function automatic logic pad_out(logic out_req, logic od_en);
    return od_en ? 1'b0 : out_req;
  endfunction

endpackage

// File: rtl/pad_io_filter.sv
// Debounce filter: accepts a new value after T consecutive mismatching cycles,
// and emits registered one-cycle rise/fall pulses aligned with data_o.
module pad_io_filter #(
  parameter int unsigned FiltCntW = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                v,
  input  logic [FiltCntW-1:0] T,
  output logic                data_o,
  output logic                rise_o,
  output logic                fall_o
);

  logic                data_q;
  logic                rise_q;
  logic                fall_q;
  logic [FiltCntW-1:0] cnt_q;
  logic [FiltCntW:0]   cnt_inc;

  // One bit wider so cnt + 1 never wraps in the compare.
  assign cnt_inc = {1'b0, cnt_q} + {{FiltCntW{1'b0}}, 1'b1};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (v == data_q) begin
        cnt_q <= '0;
      end else if (cnt_inc >= {1'b0, T}) begin
        data_q <= v;
        rise_q <= v;
        fall_q <= ~v;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_inc[FiltCntW-1:0];
      end
    end
  end

  assign data_o = data_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/pad_io_conditioner.sv
// Core-side conditioning for one bidirectional pad: synchronize, invert and
// debounce the input; register output data, enable and attributes.
module pad_io_conditioner
  import pad_io_pkg::*;
#(
  parameter int unsigned AttrDw   = pad_io_pkg::AttrDw,
  parameter int unsigned FiltCntW = pad_io_pkg::FiltCntW
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                pad_in_i,
  input  logic                invert_i,
  input  logic                filt_en_i,
  input  logic [FiltCntW-1:0] filt_thresh_i,
  output logic                data_o,
  output logic                rise_o,
  output logic                fall_o,
  input  logic                out_req_i,
  input  logic                oe_req_i,
  input  logic                od_en_i,
  input  logic [AttrDw-1:0]   attr_i,
  output logic                out_o,
  output logic                oe_o,
  output logic [AttrDw-1:0]   attr_o
);

  logic [1:0]          sync_q;
  logic                v;
  logic [FiltCntW-1:0] t_eff;
  logic                out_q;
  logic                oe_q;
  logic [AttrDw-1:0]   attr_q;

  // Local two-flop synchronizer with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], pad_in_i};
    end
  end

  assign v = sync_q[1] ^ invert_i;

  always_comb begin
    t_eff = filt_thresh_i;
    if (!filt_en_i || (filt_thresh_i == '0)) begin
      t_eff = {{(FiltCntW-1){1'b0}}, 1'b1};
    end
  end

  pad_io_filter #(
    .FiltCntW (FiltCntW)
  ) u_filter (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .v      (v),
    .T      (t_eff),
    .data_o (data_o),
    .rise_o (rise_o),
    .fall_o (fall_o)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q  <= 1'b0;
      oe_q   <= 1'b0;
      attr_q <= '0;
    end else begin
      out_q  <= pad_out(out_req_i, od_en_i);
      oe_q   <= pad_oe(oe_req_i, out_req_i, od_en_i);
      attr_q <= attr_i;
    end
  end

  assign out_o  = out_q;
  assign oe_o   = oe_q;
  assign attr_o = attr_q;

endmodule

// File: tb/tb_pad_io_conditioner.sv
// Directed bench for pad_io_conditioner with hand-computed expectations.
module tb_pad_io_conditioner;

  logic        clk = 1'b0;
  logic        rst;
  logic        pad_in;
  logic        invert;
  logic        filt_en;
  logic [15:0] filt_thresh;
  logic        data;
  logic        rise;
  logic        fall;
  logic        out_req;
  logic        oe_req;
  logic        od_en;
  logic [5:0]  attr_in;
  logic        out;
  logic        oe;
  logic [5:0]  attr_out;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  pad_io_conditioner #(
    .AttrDw   (6),
    .FiltCntW (16)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .pad_in_i      (pad_in),
    .invert_i      (invert),
    .filt_en_i     (filt_en),
    .filt_thresh_i (filt_thresh),
    .data_o        (data),
    .rise_o        (rise),
    .fall_o        (fall),
    .out_req_i     (out_req),
    .oe_req_i      (oe_req),
    .od_en_i       (od_en),
    .attr_i        (attr_in),
    .out_o         (out),
    .oe_o          (oe),
    .attr_o        (attr_out)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Checks data/rise/fall together.
  task automatic chk_in(input string tag, input logic d, input logic r, input logic f);
    chk({tag, ".data"}, {7'd0, data}, {7'd0, d});
    chk({tag, ".rise"}, {7'd0, rise}, {7'd0, r});
    chk({tag, ".fall"}, {7'd0, fall}, {7'd0, f});
  endtask

  initial begin
    rst = 1'b1; pad_in = 1'b0; invert = 1'b0; filt_en = 1'b0; filt_thresh = 16'd0;
    out_req = 1'b0; oe_req = 1'b0; od_en = 1'b0; attr_in = 6'h00;
    step(); step();
    rst = 1'b0;
    step();
    chk_in("reset", 1'b0, 1'b0, 1'b0);
    chk("reset.out", {7'd0, out}, 8'd0);
    chk("reset.oe", {7'd0, oe}, 8'd0);
    chk("reset.attr", {2'd0, attr_out}, 8'd0);

    // Filter off: 3-edge latency.
    pad_in = 1'b1;
    step(); step();                       // E0, E1
    chk_in("nofilt.e1", 1'b0, 1'b0, 1'b0);
    step();                               // E2
    chk_in("nofilt.e2", 1'b1, 1'b1, 1'b0);
    step();
    chk_in("nofilt.after", 1'b1, 1'b0, 1'b0);
    pad_in = 1'b0;
    step(); step();
    chk_in("nofilt.fall.e1", 1'b1, 1'b0, 1'b0);
    step();
    chk_in("nofilt.fall.e2", 1'b0, 1'b0, 1'b1);
    step();
    chk_in("nofilt.fall.after", 1'b0, 1'b0, 1'b0);

    // Filter T=4: a 3-cycle glitch is rejected.
    filt_en = 1'b1; filt_thresh = 16'd4;
    pad_in = 1'b1;
    step(); step(); step();
    pad_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk_in("glitch", 1'b0, 1'b0, 1'b0);
    end

    // A held level is accepted after E1+T.
    pad_in = 1'b1;
    step(); step(); step(); step(); step(); // E0..E4
    chk_in("level.e4", 1'b0, 1'b0, 1'b0);
    step();                                 // E5
    chk_in("level.e5", 1'b1, 1'b1, 1'b0);
    step();
    chk_in("level.after", 1'b1, 1'b0, 1'b0);
    pad_in = 1'b0;
    repeat (5) step();
    chk_in("level.fall.e4", 1'b1, 1'b0, 1'b0);
    step();
    chk_in("level.fall.e5", 1'b0, 1'b0, 1'b1);

    // Threshold lowered mid-count: update on the next mismatching edge.
    step();
    filt_thresh = 16'd10;
    pad_in = 1'b1;
    repeat (7) step();                      // E0..E6, cnt = 5
    chk_in("lower.e6", 1'b0, 1'b0, 1'b0);
    filt_thresh = 16'd2;
    step();                                 // E7
    chk_in("lower.e7", 1'b1, 1'b1, 1'b0);

    // Back to low with the filter off.
    filt_en = 1'b0;
    pad_in = 1'b0;
    repeat (4) step();
    chk_in("restore", 1'b0, 1'b0, 1'b0);

    // Invert toggle with pad low, filter off: one edge later.
    invert = 1'b1;
    step();
    chk_in("invert.on", 1'b1, 1'b1, 1'b0);
    // Threshold 0 with filter enabled behaves as T=1.
    filt_en = 1'b1; filt_thresh = 16'd0;
    invert = 1'b0;
    step();
    chk_in("thresh0", 1'b0, 1'b0, 1'b1);
    step();
    chk_in("thresh0.after", 1'b0, 1'b0, 1'b0);

    // Output path.
    od_en = 1'b0; out_req = 1'b1; oe_req = 1'b1; attr_in = 6'h2A;
    chk("attr.before", {2'd0, attr_out}, 8'h00);
    step();
    chk("pp.out", {7'd0, out}, 8'd1);
    chk("pp.oe", {7'd0, oe}, 8'd1);
    chk("attr.after", {2'd0, attr_out}, 8'h2A);
    od_en = 1'b1; out_req = 1'b0;
    step();
    chk("od0.out", {7'd0, out}, 8'd0);
    chk("od0.oe", {7'd0, oe}, 8'd1);
    out_req = 1'b1;
    step();
    chk("od1.out", {7'd0, out}, 8'd0);
    chk("od1.oe", {7'd0, oe}, 8'd0);
    od_en = 1'b0;
    step();
    chk("pp2.oe", {7'd0, oe}, 8'd1);

    // Reset mid-count discards the debounce in progress.
    filt_thresh = 16'd4;
    pad_in = 1'b1;
    repeat (5) step();                      // E0..E4, cnt = 3
    chk_in("rstmid.pre", 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    chk_in("rstmid.in", 1'b0, 1'b0, 1'b0);
    chk("rstmid.out", {7'd0, out}, 8'd0);
    chk("rstmid.oe", {7'd0, oe}, 8'd0);
    chk("rstmid.attr", {2'd0, attr_out}, 8'd0);
    rst = 1'b0;
    repeat (5) step();
    chk_in("rstmid.e4", 1'b0, 1'b0, 1'b0);
    step();
    chk_in("rstmid.e5", 1'b1, 1'b1, 1'b0);
    step();
    chk_in("rstmid.after", 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
